// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the processing-element network interface.
//   - default flit geometry (FLIT_W_DEF, NODES_DEF)
//   - dest_w(): address width for a given node count
//   - flit field extract/pack helpers on a width-agnostic 64-bit container.
//     Callers cast the results down to their own field widths.
// Flit layout: {dest[DEST_W], src[DEST_W], payload[FLIT_W-2*DEST_W]}.
package noc_pkg;

   localparam int FLIT_W_DEF = 20;
   localparam int NODES_DEF  = 16;
   localparam int MAX_FLIT_W = 64;

   typedef logic [MAX_FLIT_W-1:0] flit_max_t;

   function automatic int dest_w(input int nodes);
      return (nodes <= 1) ? 1 : $clog2(nodes);
   endfunction

   function automatic flit_max_t field_mask(input int bits);
      return (flit_max_t'(1) << bits) - flit_max_t'(1);
   endfunction

   function automatic flit_max_t flit_dest(input flit_max_t f, input int flit_w, input int dw);
      return (f >> (flit_w - dw)) & field_mask(dw);
   endfunction

   function automatic flit_max_t flit_src(input flit_max_t f, input int flit_w, input int dw);
      return (f >> (flit_w - 2*dw)) & field_mask(dw);
   endfunction

   function automatic flit_max_t flit_payload(input flit_max_t f, input int flit_w, input int dw);
      return f & field_mask(flit_w - 2*dw);
   endfunction

   function automatic flit_max_t flit_pack(input flit_max_t dest, input flit_max_t src,
                                           input flit_max_t pay, input int flit_w, input int dw);
      return ((dest & field_mask(dw)) << (flit_w - dw))
           | ((src & field_mask(dw)) << (flit_w - 2*dw))
           | (pay & field_mask(flit_w - 2*dw));
   endfunction

endpackage

// File: rtl/pe_credit_ni_if.sv
// pe_credit_ni_if: host-side and router-side signals of the PE network interface.
//   injection : inj_valid, inj_dest, inj_payload -> NI ; inj_ready <- NI
//   router tx : dataout, out_valid <- NI ; ci -> NI
//   router rx : datain, in_valid -> NI ; co <- NI
//   host rx   : rx_valid, rx_data, read, misroute, credit_err <- NI ; clr -> NI
// modport slave is the NI itself, modport master is the host/router environment.
interface pe_credit_ni_if import noc_pkg::*; #(
   parameter int FLIT_W = FLIT_W_DEF,
   parameter int NODES  = NODES_DEF
);
   localparam int DEST_W = dest_w(NODES);
   localparam int PAY_W  = FLIT_W - 2*DEST_W;

   logic              inj_valid;
   logic [DEST_W-1:0] inj_dest;
   logic [PAY_W-1:0]  inj_payload;
   logic              inj_ready;
   logic [FLIT_W-1:0] dataout;
   logic              out_valid;
   logic              ci;
   logic [FLIT_W-1:0] datain;
   logic              in_valid;
   logic              co;
   logic              rx_valid;
   logic [FLIT_W-1:0] rx_data;
   logic [NODES-1:0]  read;
   logic              clr;
   logic              misroute;
   logic              credit_err;

   modport slave (
      input  inj_valid, inj_dest, inj_payload, ci, datain, in_valid, clr,
      output inj_ready, dataout, out_valid, co, rx_valid, rx_data, read, misroute, credit_err
   );

   modport master (
      output inj_valid, inj_dest, inj_payload, ci, datain, in_valid, clr,
      input  inj_ready, dataout, out_valid, co, rx_valid, rx_data, read, misroute, credit_err
   );

endinterface

// File: rtl/pe_inj_fifo.sv
// pe_inj_fifo: count-based injection FIFO with wrap-around pointers.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write din when push (caller guarantees !full)
//   pop          : drop the head entry (caller guarantees !empty)
//   head         : current head entry (contents undefined when empty)
//   full, empty  : occupancy flags from registered count
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module pe_inj_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // simultaneous push and pop leaves the count unchanged
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: head is only consumed when the FIFO is non-empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/pe_credit_ni.sv
// pe_credit_ni: credit-based processing-element network interface.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pe_credit_ni_if.slave (injection, router tx/rx, host rx, sticky flags)
// Injection: host flits are queued in pe_inj_fifo with src = NODE_ID and sent to the
// router one per cycle whenever a credit is held. There is no downstream ready, so
// out_valid itself is the transfer strobe.
// Ejection: every router flit is accepted, registered to rx_data/rx_valid and answered
// with a one-cycle co credit; arrivals for this node mark read[src], others set misroute.
module pe_credit_ni import noc_pkg::*; #(
   parameter int FLIT_W    = FLIT_W_DEF,
   parameter int NODES     = NODES_DEF,
   parameter int NODE_ID   = 15,
   parameter int CREDITS   = 7,
   parameter int INJ_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   pe_credit_ni_if.slave  bus
);
   localparam int DEST_W = dest_w(NODES);
   localparam int CRD_W  = $clog2(CREDITS + 1);
   localparam logic [DEST_W-1:0] MY_ID   = DEST_W'(NODE_ID);
   localparam logic [CRD_W-1:0]  CRD_MAX = CRD_W'(CREDITS);

   logic              push;
   logic              send;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FLIT_W-1:0] inj_flit;
   logic [FLIT_W-1:0] fifo_head;
   logic [DEST_W-1:0] rx_dest;
   logic [DEST_W-1:0] rx_src;

   logic [CRD_W-1:0]  credit_q, credit_d;
   logic              credit_err_q, credit_err_d;
   logic              misroute_q, misroute_d;
   logic [NODES-1:0]  read_q, read_d;
   logic              rx_valid_q, rx_valid_d;
   logic [FLIT_W-1:0] rx_data_q, rx_data_d;
   logic              co_q, co_d;

   // injection side
   assign bus.inj_ready = !fifo_full && !rst;
   assign push          = bus.inj_valid && bus.inj_ready;
   assign inj_flit      = FLIT_W'(flit_pack(flit_max_t'(bus.inj_dest), flit_max_t'(MY_ID),
                                            flit_max_t'(bus.inj_payload), FLIT_W, DEST_W));

   pe_inj_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (INJ_DEPTH)
   ) u_inj_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (send),
      .din   (inj_flit),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign send          = !fifo_empty && (credit_q != '0);
   assign bus.out_valid = send;
   assign bus.dataout   = fifo_empty ? '0 : fifo_head;

   // ejection field decode
   assign rx_dest = DEST_W'(flit_dest(flit_max_t'(bus.datain), FLIT_W, DEST_W));
   assign rx_src  = DEST_W'(flit_src(flit_max_t'(bus.datain), FLIT_W, DEST_W));

   always_comb begin
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      misroute_d   = misroute_q;
      read_d       = read_q;
      rx_valid_d   = bus.in_valid;
      co_d         = bus.in_valid;
      rx_data_d    = bus.in_valid ? bus.datain : rx_data_q;

      // a returned credit with the counter already full is dropped and flagged
      if (send && !bus.ci) begin
         credit_d = credit_q - CRD_W'(1);
      end else if (bus.ci && !send) begin
         if (credit_q == CRD_MAX) begin
            credit_err_d = 1'b1;
         end else begin
            credit_d = credit_q + CRD_W'(1);
         end
      end

      // clear first so a same-cycle set overrides it
      if (bus.clr) begin
         read_d       = '0;
         misroute_d   = 1'b0;
         if (!(bus.ci && !send && credit_q == CRD_MAX)) begin
            credit_err_d = 1'b0;
         end
      end

      if (bus.in_valid) begin
         if (rx_dest == MY_ID) begin
            read_d[rx_src] = 1'b1;
         end else begin
            misroute_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q     <= CRD_MAX;
         credit_err_q <= 1'b0;
         misroute_q   <= 1'b0;
         read_q       <= '0;
         rx_valid_q   <= 1'b0;
         rx_data_q    <= '0;
         co_q         <= 1'b0;
      end else begin
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
         misroute_q   <= misroute_d;
         read_q       <= read_d;
         rx_valid_q   <= rx_valid_d;
         rx_data_q    <= rx_data_d;
         co_q         <= co_d;
      end
   end

   assign bus.co         = co_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.read       = read_q;
   assign bus.misroute   = misroute_q;
   assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_pe_credit_ni.sv
// tb_pe_credit_ni: directed self-checking bench for pe_credit_ni with default
// parameters (FLIT_W=20, NODES=16, NODE_ID=15, CREDITS=7, INJ_DEPTH=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there.
module tb_pe_credit_ni;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   pe_credit_ni_if #(.FLIT_W(20), .NODES(16)) bus ();

   pe_credit_ni #(
      .FLIT_W    (20),
      .NODES     (16),
      .NODE_ID   (15),
      .CREDITS   (7),
      .INJ_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] fl(input int d, input int s, input int p);
      logic [31:0] dv, sv, pv;
      dv = d; sv = s; pv = p;
      return {dv[3:0], sv[3:0], pv[11:0]};
   endfunction

   int next_push;
   int exp_out;
   int sent;
   logic acc;

   initial begin
      rst             = 1'b1;
      bus.inj_valid   = 1'b0;
      bus.inj_dest    = '0;
      bus.inj_payload = '0;
      bus.ci          = 1'b0;
      bus.datain      = '0;
      bus.in_valid    = 1'b0;
      bus.clr         = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_inj_ready_low", bus.inj_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst_inj_ready", bus.inj_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_dataout", bus.dataout, 0);
      chk("rst_co", bus.co, 0);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_read", bus.read, 0);
      chk("rst_misroute", bus.misroute, 0);
      chk("rst_credit_err", bus.credit_err, 0);
      chk("rst_credit", dut.credit_q, 7);

      // credit drain: 10 flits, 7 credits
      for (int k = 1; k <= 10; k++) begin
         bus.inj_valid   = 1'b1;
         bus.inj_dest    = 4'd3;
         bus.inj_payload = 12'(k);
         tick();
         chk("drain_ov", bus.out_valid, (k <= 7) ? 1 : 0);
         chk("drain_data", bus.dataout, fl(3, 15, (k <= 7) ? k : 8));
      end
      bus.inj_valid = 1'b0;
      tick();
      chk("drain_stall_ov", bus.out_valid, 0);
      chk("drain_stall_data", bus.dataout, fl(3, 15, 8));
      chk("drain_credit0", dut.credit_q, 0);
      for (int i = 0; i < 3; i++) begin
         bus.ci = 1'b1;
         tick();
         chk("release_ov", bus.out_valid, 1);
         chk("release_data", bus.dataout, fl(3, 15, 8 + i));
      end
      bus.ci = 1'b0;
      tick();
      chk("release_done_ov", bus.out_valid, 0);
      chk("release_done_data", bus.dataout, 0);
      chk("release_done_credit", dut.credit_q, 0);

      // simultaneous send + ci with credit held at 2
      bus.ci = 1'b1;
      tick();
      tick();
      bus.ci = 1'b0;
      chk("simul_credit_pre", dut.credit_q, 2);
      bus.inj_valid   = 1'b1;
      bus.inj_payload = 12'h011;
      tick();
      chk("simul_ov_first", bus.out_valid, 1);
      chk("simul_data_first", bus.dataout, fl(3, 15, 'h011));
      for (int i = 2; i <= 5; i++) begin
         bus.inj_payload = 12'(16 + i);
         bus.ci          = 1'b1;
         tick();
         chk("simul_ov", bus.out_valid, 1);
         chk("simul_data", bus.dataout, fl(3, 15, 16 + i));
         chk("simul_credit", dut.credit_q, 2);
      end
      bus.inj_valid = 1'b0;
      bus.ci        = 1'b1;
      tick();
      bus.ci = 1'b0;
      chk("simul_end_ov", bus.out_valid, 0);
      chk("simul_end_credit", dut.credit_q, 2);

      // credit overflow and clr priority
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.ci = 1'b1;
      tick();
      chk("ovf_err", bus.credit_err, 1);
      chk("ovf_credit", dut.credit_q, 7);
      bus.ci  = 1'b0;
      bus.clr = 1'b1;
      tick();
      chk("ovf_clr", bus.credit_err, 0);
      bus.ci = 1'b1;
      tick();
      chk("ovf_set_wins", bus.credit_err, 1);
      bus.ci = 1'b0;
      tick();
      bus.clr = 1'b0;
      chk("ovf_clr2", bus.credit_err, 0);

      // ejection
      bus.in_valid = 1'b1;
      bus.datain   = 20'hF4ABC;
      tick();
      chk("ej1_rx_valid", bus.rx_valid, 1);
      chk("ej1_co", bus.co, 1);
      chk("ej1_rx_data", bus.rx_data, 20'hF4ABC);
      chk("ej1_read", bus.read, 16'h0010);
      chk("ej1_misroute", bus.misroute, 0);
      bus.datain = 20'hF9123;
      tick();
      chk("ej2_co", bus.co, 1);
      chk("ej2_rx_data", bus.rx_data, 20'hF9123);
      chk("ej2_read", bus.read, 16'h0210);
      bus.datain = 20'h21456;
      tick();
      chk("ej3_co", bus.co, 1);
      chk("ej3_rx_data", bus.rx_data, 20'h21456);
      chk("ej3_read", bus.read, 16'h0210);
      chk("ej3_misroute", bus.misroute, 1);
      bus.in_valid = 1'b0;
      tick();
      chk("ej_idle_rx_valid", bus.rx_valid, 0);
      chk("ej_idle_co", bus.co, 0);
      chk("ej_idle_read", bus.read, 16'h0210);
      chk("ej_idle_misroute", bus.misroute, 1);
      bus.clr      = 1'b1;
      bus.in_valid = 1'b1;
      bus.datain   = 20'hF0000;
      tick();
      chk("ej_clr_set_read", bus.read, 16'h0001);
      chk("ej_clr_misroute", bus.misroute, 0);
      bus.in_valid = 1'b0;
      tick();
      bus.clr = 1'b0;
      chk("ej_clr_read", bus.read, 0);

      // FIFO full / wrap: drain credits first
      for (int i = 0; i < 7; i++) begin
         bus.inj_valid   = 1'b1;
         bus.inj_payload = 12'(224 + i);
         tick();
      end
      bus.inj_valid = 1'b0;
      tick();
      chk("wrap_credit0", dut.credit_q, 0);
      chk("wrap_empty_ov", bus.out_valid, 0);
      for (int i = 1; i <= 4; i++) begin
         bus.inj_valid   = 1'b1;
         bus.inj_payload = 12'(256 + i);
         tick();
         chk("wrap_fill_ready", bus.inj_ready, (i < 4) ? 1 : 0);
      end
      bus.inj_payload = 12'h105;
      tick();
      chk("wrap_refused_ready", bus.inj_ready, 0);
      chk("wrap_refused_ov", bus.out_valid, 0);
      chk("wrap_head", bus.dataout, fl(3, 15, 'h101));

      next_push = 'h105;
      exp_out   = 'h101;
      sent      = 0;
      for (int c = 0; c < 8; c++) begin
         bus.ci          = (c < 4);
         bus.inj_valid   = (next_push <= 'h108);
         bus.inj_payload = 12'(next_push);
         acc = bus.inj_valid && bus.inj_ready;
         if (bus.out_valid) begin
            chk("wrap_order", bus.dataout, fl(3, 15, exp_out));
            exp_out++;
            sent++;
         end
         tick();
         if (acc) next_push++;
      end
      chk("wrap_sent_a", sent, 4);
      chk("wrap_pushed", next_push, 'h109);
      chk("wrap_full_again", bus.inj_ready, 0);
      for (int c = 0; c < 8; c++) begin
         bus.ci        = (c < 4);
         bus.inj_valid = 1'b0;
         if (bus.out_valid) begin
            chk("wrap_order2", bus.dataout, fl(3, 15, exp_out));
            exp_out++;
            sent++;
         end
         tick();
      end
      bus.ci = 1'b0;
      chk("wrap_sent_total", sent, 8);
      chk("wrap_final_ov", bus.out_valid, 0);
      chk("wrap_final_data", bus.dataout, 0);

      // reset mid-stream
      bus.in_valid = 1'b1;
      bus.datain   = 20'hF5000;
      for (int i = 1; i <= 3; i++) begin
         bus.inj_valid   = 1'b1;
         bus.inj_payload = 12'(512 + i);
         tick();
         bus.in_valid = 1'b0;
      end
      bus.inj_valid = 1'b0;
      bus.ci        = 1'b1;
      tick();
      bus.ci = 1'b0;
      chk("mid_credit1", dut.credit_q, 1);
      chk("mid_ov", bus.out_valid, 1);
      chk("mid_read", bus.read, 16'h0020);
      rst = 1'b1;
      tick();
      chk("mid_rst_ov", bus.out_valid, 0);
      chk("mid_rst_credit", dut.credit_q, 7);
      chk("mid_rst_read", bus.read, 0);
      chk("mid_rst_ready", bus.inj_ready, 0);
      chk("mid_rst_data", bus.dataout, 0);
      rst             = 1'b0;
      bus.inj_valid   = 1'b1;
      bus.inj_payload = 12'h301;
      tick();
      bus.inj_valid = 1'b0;
      chk("mid_post_ov", bus.out_valid, 1);
      chk("mid_post_data", bus.dataout, fl(3, 15, 'h301));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_credit_ni.md
# pe_credit_ni

Parametrised processing-element network interface, the successor to the fixed 20-bit single-node PE. It sits between a local traffic source/sink and one router port. The injection side has a FIFO and a credit counter of configurable depth, and never sends without a credit. The ejection side checks destination, records per-source arrivals, flags misrouted flits, and returns one credit per accepted flit.

## Interface
- FLIT_W, 20, flit width. Layout: dest = [FLIT_W-1 -: DEST_W], src = next DEST_W bits, payload = remaining low bits. Requires FLIT_W > 2*DEST_W.
- NODES, 16, node count. DEST_W = clog2(NODES).
- NODE_ID, 15, this node's address.
- CREDITS, 7, downstream buffer slots; credit counter maximum.
- INJ_DEPTH, 4, injection FIFO depth, power of 2, ≥2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- inj_valid  in  1  host offers a flit.
- inj_dest  in  DEST_W  destination of offered flit.
- inj_payload  in  FLIT_W-2*DEST_W  payload of offered flit.
- inj_ready  out  1  FIFO not full.
- dataout  out  FLIT_W  flit to router, {dest, NODE_ID, payload}.
- out_valid  out  1  flit on dataout is transferred this cycle.
- ci  in  1  credit return from router, one slot per cycle high.
- datain  in  FLIT_W  flit from router.
- in_valid  in  1  datain valid; always accepted.
- co  out  1  credit return to router.
- rx_valid  out  1  registered received-flit strobe.
- rx_data  out  FLIT_W  registered received flit.
- read  out  NODES  sticky per-source arrival bitmap.
- clr  in  1  clears read, misroute and credit_err.
- misroute  out  1  sticky: flit received with dest ≠ NODE_ID.
- credit_err  out  1  sticky: ci received with counter already at CREDITS.

## Operation
- Injection push: a flit is pushed when inj_valid && inj_ready. src field = NODE_ID.
- inj_ready = !full, computed from registered state. A push while full is impossible by construction.
- Send: out_valid = !empty && (credit != 0). dataout = FIFO head, and is 0 when empty.
- There is no downstream ready signal. Every cycle with out_valid high sends exactly one flit, pops the FIFO and consumes one credit.
- Credit counter, range 0..CREDITS, width clog2(CREDITS+1):
  - send only: decrement.
  - ci only: increment.
  - send and ci together: unchanged.
  - ci with no send while counter = CREDITS: counter holds, credit_err set.
- Ejection, on in_valid:
  - rx_data ← datain, rx_valid ← 1, co ← 1.
  - If dest == NODE_ID: read[src] ← 1. Otherwise misroute ← 1 and read is unchanged.
  - A credit is returned for every accepted flit, including misrouted ones.
- clr: clears read, misroute and credit_err. It loses to a same-cycle set, so the set wins.
- FIFO push and pop in the same cycle, including at full−1 and at 1 entry: both take effect and the count is unchanged.

## Timing
- Reset (rst high at a clk edge):
  - credit = CREDITS, FIFO empty.
  - dataout, out_valid, co, rx_valid, rx_data, read, misroute, credit_err = 0.
  - inj_ready = 0 while rst is high, and 1 on the first cycle after.
- Reset mid-operation flushes all FIFO contents and restores full credits. In-flight credits are not preserved.
- Injection latency: flit pushed at edge N is visible on dataout/out_valid in the cycle after edge N, provided the FIFO was empty and credit > 0.
- Throughput: 1 flit/cycle while credits remain. With credit = 0, out_valid is held low and dataout shows the head.
- A ci at edge N makes out_valid possible in the cycle after N.
- Ejection: in_valid at edge N gives rx_valid, co and the read/misroute update visible after edge N. All are single-cycle pulses except the sticky bits.
- Back-to-back in_valid produces back-to-back co pulses.

## Structure
- Shared package noc_pkg:
  - DEST_W function (clog2).
  - Flit field extract/pack functions: dest, src, payload.
  - Default constants FLIT_W=20, NODES=16.
- Sub-module pe_inj_fifo, parametrised by width and depth:
  - Inputs push, pop. Outputs head, full, empty.
  - Count-based, with wrap-around read/write pointers.
- Credit counter, ejection logic and sticky flags live in the top level.

## Test plan
- Reset then credit drain: CREDITS=7, push 10 flits to dest 3 with payloads 0x001..0x00A and no ci. Required: exactly 7 out_valid cycles carrying 0x001..0x007, then out_valid=0 with dataout showing the 0x008 flit. Three ci pulses then release 0x008..0x00A.
- Simultaneous send + ci: hold credit at 2, pulse ci on every send cycle for 5 sends. Required: credit stays 2 and all 5 flits go out back-to-back.
- Credit overflow: after reset, pulse ci once. Required: credit_err=1 and counter stays 7. A clr the following cycle returns credit_err to 0.
- Ejection: in_valid with flit dest=15, src=4, then dest=15, src=9, then dest=2, src=1. Required: read=0x0210, misroute=1, three co pulses, and rx_data matching each flit one cycle later.
- FIFO full/wrap: no credits available (drained), INJ_DEPTH=4. Push until inj_ready=0 (4 accepted, 5th refused). Then give 4 ci with continuous pushes. Required: FIFO order preserved across pointer wrap and no flit lost or duplicated.
- Reset mid-stream: rst high with 3 flits queued and credit=1. Required: next cycle out_valid=0, credit=7, read=0. The first push afterwards appears after 1 cycle.
